mux4x1_rr_arbiter: RTL and testbench
====================================

// Module: mux4x1_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one 4:1 mux datapath among four requesters.
//  Grants one requester at a time and drives the mux select pair {sel1,sel0} to match.
//  Forces the owner off after MAX_HOLD cycles when another requester is waiting.
//  Sits directly in front of the 4:1 mux select inputs; sel1/sel0 connect 1:1.
// PARAMETERS
//  MAX_HOLD  8  max consecutive grant cycles while others wait; legal range 2..2^CNT_W
//  CNT_W     3  hold-counter width; must satisfy 2^CNT_W >= MAX_HOLD
// PORTS
//  clk      in   1  rising-edge clock
//  rst_n    in   1  asynchronous active-low reset
//  req      in   4  request per source; req[i] held high while source i needs the mux
//  gnt      out  4  one-hot registered grant; all-zero when idle
//  sel1     out  1  mux select MSB = owner index bit 1
//  sel0     out  1  mux select LSB = owner index bit 0
//  busy     out  1  1 while any grant is active (== |gnt)
//  preempt  out  1  one-cycle pulse on the edge an owner is forced off by timeout
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, gnt=4'b0000, {sel1,sel0}=2'b00, busy=0, preempt=0,
//   hold_cnt=0, last=2'd3 (so req[0] has highest priority after reset).
//  All outputs are registered. Reset release takes effect at the next rising edge.
//  Priority: search order last+1, last+2, last+3, last (mod 4); first set req wins.
//  FSM states: IDLE, GRANT.
//  IDLE:
//   - No req -> stay IDLE. gnt=0; sel holds the last owner index.
//   - Any req -> next edge: GRANT, gnt=onehot(winner), sel=winner, last=winner, hold_cnt=0.
//   - Latency: req sampled high at edge N gives gnt high after edge N+1 (1 cycle).
//  GRANT (owner = last):
//   - req[owner]=1, hold_cnt<MAX_HOLD-1 -> keep grant; hold_cnt++.
//   - req[owner]=1, hold_cnt==MAX_HOLD-1, another req set -> preempt:
//     switch to the winner of the remaining requesters (owner excluded), hold_cnt=0, preempt=1.
//   - req[owner]=1, hold_cnt==MAX_HOLD-1, no other req -> keep grant; hold_cnt saturates; no preempt.
//   - req[owner]=0, another req set -> hand over on the same edge: gnt switches one-hot to
//     one-hot with no idle gap; hold_cnt=0.
//   - req[owner]=0, no other req -> IDLE; gnt=0.
//  Invariants:
//   - gnt is always zero or one-hot.
//   - {sel1,sel0} changes only on the edge where gnt changes.
//   - gnt never goes to a source whose req was low at the deciding edge.
//  Simultaneous events: a release and new requests on the same edge resolve from last+1;
//   the owner that just released is never re-granted on that edge.
//  Fairness: with all four requesting continuously, grants rotate 0->1->2->3->0,
//   MAX_HOLD cycles each.
//  Reset mid-grant: gnt drops to 0 asynchronously; after release, arbitration restarts from req[0].
// TESTING
//  1. Reset with req=4'b1111, release rst_n -> 1 cycle later gnt=0001, sel=00;
//     after 8 cycles gnt=0010, preempt pulses once.
//  2. req=4'b0100 alone held for 20 cycles -> gnt=0100, sel=10 throughout; no preempt, hold_cnt saturates.
//  3. Owner 1 drops req while req=4'b1001 -> next edge gnt=1000, sel=11, busy stays 1 (no gap).
//  4. All req drop -> gnt=0000, busy=0, sel keeps last index; then req=4'b0001 -> gnt=0001 after 1 cycle.
//  5. rst_n pulsed low mid-grant of source 2 -> gnt=0 immediately;
//     with req=4'b0101 after release -> gnt=0001.
//  6. Random req stream for 10k cycles -> check one-hot/zero gnt, sel==index(gnt),
//     wait <= 3*MAX_HOLD cycles for every requester.

Source files
------------

// File: rtl/mux4x1_rr_arbiter.sv
// Round-robin arbiter that hands one shared 4:1 mux datapath to one of four
// requesters at a time. It drives the mux select pair to match the grant and
// forces an owner off after MAX_HOLD cycles while another source is waiting.
module mux4x1_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       sel1,
    output logic       sel0,
    output logic       busy,
    output logic       preempt
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Last hold-counter value before a waiting requester may take over.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [1:0]       last_q, last_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             busy_q, busy_d;
    logic             preempt_q, preempt_d;

    logic [2:0]       pick_any_s;
    logic [2:0]       pick_other_s;

    // Circular search starting at from+1 and ending at from itself.
    // Returns {found, index}. With skip_from set, the previous owner is never
    // selected, which keeps a releasing or preempted owner off this edge.
    function automatic logic [2:0] rr_pick(input logic [3:0] r,
                                           input logic [1:0] from,
                                           input logic       skip_from);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            idx = from + 2'(k);
            if (!res[2] && r[idx] && !(skip_from && (k == 4))) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // One-hot decode of a source index.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] oh;
        oh = 4'b0000;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    assign pick_any_s   = rr_pick(req, last_q, 1'b0);
    assign pick_other_s = rr_pick(req, last_q, 1'b1);

    // Next-state and next-output decision for the IDLE/GRANT arbiter.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any_s[2]) begin
                    state_d = ST_GRANT;
                    last_d  = pick_any_s[1:0];
                    gnt_d   = onehot4(pick_any_s[1:0]);
                    sel_d   = pick_any_s[1:0];
                    hold_d  = {CNT_W{1'b0}};
                end else begin
                    gnt_d = 4'b0000;
                end
            end
            ST_GRANT: begin
                if (req[last_q]) begin
                    if (hold_q != HOLD_LAST) begin
                        hold_d = hold_q + CNT_W'(1);
                    end else if (pick_other_s[2]) begin
                        // Timeout with someone waiting: force the owner off.
                        last_d    = pick_other_s[1:0];
                        gnt_d     = onehot4(pick_other_s[1:0]);
                        sel_d     = pick_other_s[1:0];
                        hold_d    = {CNT_W{1'b0}};
                        preempt_d = 1'b1;
                    end else begin
                        // Nobody waiting: keep the grant, counter saturates.
                        hold_d = hold_q;
                    end
                end else begin
                    if (pick_other_s[2]) begin
                        // Release with others waiting: switch with no idle gap.
                        last_d = pick_other_s[1:0];
                        gnt_d  = onehot4(pick_other_s[1:0]);
                        sel_d  = pick_other_s[1:0];
                        hold_d = {CNT_W{1'b0}};
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = 4'b0000;
                        hold_d  = {CNT_W{1'b0}};
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 4'b0000;
                hold_d  = {CNT_W{1'b0}};
            end
        endcase
        busy_d = |gnt_d;
    end

    // State and registered outputs; async reset points the search at source 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            last_q    <= 2'd3;
            gnt_q     <= 4'b0000;
            sel_q     <= 2'b00;
            hold_q    <= {CNT_W{1'b0}};
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            hold_q    <= hold_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel1    = sel_q[1];
    assign sel0    = sel_q[0];
    assign busy    = busy_q;
    assign preempt = preempt_q;

endmodule

// File: tb/tb_mux4x1_rr_arbiter.sv
// Self-checking bench for mux4x1_rr_arbiter: directed vector table, a
// hand-written reset/preempt sequence and a random request stream.
module tb_mux4x1_rr_arbiter;

    localparam int MAX_HOLD = 8;
    localparam int CNT_W    = 3;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       sel1;
    logic       sel0;
    logic       busy;
    logic       preempt;

    mux4x1_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .gnt    (gnt),
        .sel1   (sel1),
        .sel0   (sel0),
        .busy   (busy),
        .preempt(preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       pre;
    } vec_t;

    typedef struct {
        int         tag;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       pre;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add_vec(input logic r, input logic [3:0] rq, input logic [3:0] gn,
                           input logic [1:0] s, input logic b, input logic p);
        vec_t v;
        v.rst_n = r; v.req = rq; v.gnt = gn; v.sel = s; v.busy = b; v.pre = p;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string name, input int tag, input logic [3:0] got,
                       input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s tag%0d: got %b expected %b", name, tag, got, want);
        end
    endtask

    task automatic check_out();
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = exp_q.pop_front();
            cmp("gnt", e.tag, gnt, e.gnt);
            cmp("sel", e.tag, {2'b00, sel1, sel0}, {2'b00, e.sel});
            cmp("busy", e.tag, {3'b000, busy}, {3'b000, e.busy});
            cmp("preempt", e.tag, {3'b000, preempt}, {3'b000, e.pre});
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, check after the edge.
    task automatic step(input int tag, input logic r, input logic [3:0] rq,
                        input logic [3:0] gn, input logic [1:0] s, input logic b,
                        input logic p);
        exp_t e;
        @(negedge clk);
        rst_n = r;
        req   = rq;
        e.tag = tag; e.gnt = gn; e.sel = s; e.busy = b; e.pre = p;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        case (g)
            4'b0001: idx_of = 2'd0;
            4'b0010: idx_of = 2'd1;
            4'b0100: idx_of = 2'd2;
            4'b1000: idx_of = 2'd3;
            default: idx_of = 2'd0;
        endcase
    endfunction

    logic [3:0] prev_gnt;
    logic [1:0] prev_sel;
    int         wait_cnt[4];

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;

        // Reset, then all four requesting: source 0 first, preempted after 8.
        add_vec(1'b0, 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0);
        add_vec(1'b0, 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0);
        add_vec(1'b1, 4'b1111, 4'b0001, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) add_vec(1'b1, 4'b1111, 4'b0001, 2'b00, 1'b1, 1'b0);
        add_vec(1'b1, 4'b1111, 4'b0010, 2'b01, 1'b1, 1'b1);
        add_vec(1'b1, 4'b1111, 4'b0010, 2'b01, 1'b1, 1'b0);
        // Owner 1 releases while 0 and 3 wait: search from 2 picks 3, no gap.
        add_vec(1'b1, 4'b1001, 4'b1000, 2'b11, 1'b1, 1'b0);
        // Everything drops: idle, select keeps 3.
        add_vec(1'b1, 4'b0000, 4'b0000, 2'b11, 1'b0, 1'b0);
        add_vec(1'b1, 4'b0000, 4'b0000, 2'b11, 1'b0, 1'b0);
        add_vec(1'b1, 4'b0001, 4'b0001, 2'b00, 1'b1, 1'b0);
        // Source 2 alone, held long enough for the counter to saturate.
        add_vec(1'b1, 4'b0100, 4'b0100, 2'b10, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) add_vec(1'b1, 4'b0100, 4'b0100, 2'b10, 1'b1, 1'b0);
        // Saturated owner with a newcomer: preempted on the very next edge.
        add_vec(1'b1, 4'b1100, 4'b1000, 2'b11, 1'b1, 1'b1);
        add_vec(1'b1, 4'b1100, 4'b1000, 2'b11, 1'b1, 1'b0);
        add_vec(1'b1, 4'b0100, 4'b0100, 2'b10, 1'b1, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(i, vecs[i].rst_n, vecs[i].req, vecs[i].gnt, vecs[i].sel,
                 vecs[i].busy, vecs[i].pre);
        end

        // Reset pulsed mid-grant of source 2: grant must drop without a clock edge.
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0101;
        #1;
        cmp("async_gnt", 100, gnt, 4'b0000);
        cmp("async_busy", 100, {3'b000, busy}, 4'b0000);
        step(101, 1'b0, 4'b0101, 4'b0000, 2'b00, 1'b0, 1'b0);
        step(102, 1'b1, 4'b0101, 4'b0001, 2'b00, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) step(103 + k, 1'b1, 4'b0101, 4'b0001, 2'b00, 1'b1, 1'b0);
        step(110, 1'b1, 4'b0101, 4'b0100, 2'b10, 1'b1, 1'b1);
        step(111, 1'b1, 4'b0101, 4'b0100, 2'b10, 1'b1, 1'b0);

        // Random stream with sticky request bits; invariants and wait bound.
        prev_gnt = gnt;
        prev_sel = {sel1, sel0};
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            checks++;
            if (!$onehot0(gnt)) begin
                errors++;
                $display("FAIL onehot cyc%0d: got %b expected zero or one-hot", c, gnt);
            end
            if (gnt != 4'b0000) begin
                cmp("sel_idx", c, {2'b00, sel1, sel0}, {2'b00, idx_of(gnt)});
            end
            cmp("busy_or", c, {3'b000, busy}, {3'b000, |gnt});
            cmp("gnt_req", c, gnt & ~req, 4'b0000);
            if ({sel1, sel0} != prev_sel) begin
                cmp("sel_edge", c, {3'b000, gnt != prev_gnt}, 4'b0001);
            end
            if (preempt) begin
                cmp("pre_switch", c, {3'b000, (gnt != prev_gnt) && (prev_gnt != 4'b0000)}, 4'b0001);
            end
            for (int i = 0; i < 4; i++) begin
                if (req[i] && !gnt[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                checks++;
                if (wait_cnt[i] > 3 * MAX_HOLD) begin
                    errors++;
                    $display("FAIL wait src%0d cyc%0d: got %0d cycles expected <= %0d",
                             i, c, wait_cnt[i], 3 * MAX_HOLD);
                    wait_cnt[i] = 0;
                end
            end
            prev_gnt = gnt;
            prev_sel = {sel1, sel0};
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
            end
        end

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: got %0d entries expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
